// File: rtl/irq_ctrl_pkg.sv
// Shared register indices, FSM encodings and the CURRENT register layout for irq_ctrl.
package irq_ctrl_pkg;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_MODE    = 3'd2;
  localparam logic [2:0] IRQ_CURRENT = 3'd3;
  localparam logic [2:0] IRQ_EOI     = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } irq_cur_t;

  function automatic logic [31:0] cur_word(input irq_cur_t c);
    return {c.vld, 28'b0, c.id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder; any=0 leaves id at 0.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [2:0]   id,
  output logic         any
);

  always_comb begin
    id  = 3'd0;
    any = 1'b0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latched sources, enable mask, fixed priority, EOI handshake.
// irq_src edge to irq_out is 3 clk; IRQ_CTRL_SYNC_EN adds a two-flop synchronizer (+2 clk).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              irq_ack,
  output logic              irq_out
);

  logic [N_SRC-1:0] src_in;
  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [2:0]       reg_sel;
  logic [2:0]       sel_id;
  logic             elig_any;
  logic             ack_take;
  logic             wr_pending;
  logic             wr_enable;
  logic             wr_mode;
  logic             wr_eoi;
  irq_state_t       state;
  irq_cur_t         cur;
  logic             unused_bits;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync_q1;
  logic [N_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_in = sync_q2;
`else
  assign src_in = irq_src;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      src_s    <= '0;
      src_prev <= '0;
    end else begin
      src_s    <= src_in;
      src_prev <= src_s;
    end
  end

  assign reg_sel    = Addr[4:2];
  assign wr_pending = WE && (reg_sel == IRQ_PENDING);
  assign wr_enable  = WE && (reg_sel == IRQ_ENABLE);
  assign wr_mode    = WE && (reg_sel == IRQ_MODE);
  assign wr_eoi     = WE && (reg_sel == IRQ_EOI);

  assign eligible = pending & enable;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req (eligible),
    .id  (sel_id),
    .any (elig_any)
  );

  assign ack_take = (state == REQ) && irq_ack && elig_any;
  assign edge_det = src_s & ~src_prev;
  assign w1c      = wr_pending ? Din[N_SRC-1:0] : '0;
  assign ack_clr  = ack_take ? (N_SRC'(1) << sel_id) : '0;

  // Edge bits: a new edge beats any clear in the same cycle. Level bits track the sampled line.
  assign pending_nxt = (mode & (edge_det | (pending & ~w1c & ~ack_clr))) | (~mode & src_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr_enable) enable <= Din[N_SRC-1:0];
      if (wr_mode)   mode   <= Din[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      irq_out <= 1'b0;
      cur     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (elig_any) begin
            state   <= REQ;
            irq_out <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq_out <= 1'b0;
            if (elig_any) begin
              cur   <= irq_cur_t'{vld: 1'b1, id: sel_id};
              state <= SERVICE;
            end else begin
              cur.vld <= 1'b0;
              state   <= IDLE;
            end
          end else if (!elig_any) begin
            irq_out <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            cur.vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      IRQ_PENDING: Dout[N_SRC-1:0] = pending;
      IRQ_ENABLE:  Dout[N_SRC-1:0] = enable;
      IRQ_MODE:    Dout[N_SRC-1:0] = mode;
      IRQ_CURRENT: Dout = cur_word(cur);
      default:     Dout = '0;
    endcase
  end

  assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

endmodule
